conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Control FSM that sequences one convolution layer over the shared single-channel conv engine. For each output channel, the engine runs once per input channel, and partial sums accumulate in the output buffer.
- Generates per-pass base addresses for input feature map, weights and output map.
- Generates accumulate/last-pass flags for the engine.
- Reports per-output-channel (cout_done) and per-layer (layer_done) completion to the top level.

Parameters:
H, 28, input feature map height
W, 28, input feature map width
IC, 3, input channels
OC, 7, output channels
K, 3, kernel size (square, stride 1, no padding)
ADDR_W, 16, width of all address outputs
TIMEOUT, 4096, watchdog limit in cycles; used only with CONV_SEQ_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin layer; sampled only in IDLE
busy  out  1  high in every state except IDLE
eng_start  out  1  single-cycle pulse to launch one engine pass
eng_done  in  1  engine pass complete; sampled only in WAIT
eng_accum  out  1  0 on ic==0 (overwrite output), 1 otherwise (accumulate)
eng_last_ic  out  1  1 on ic==IC-1 (engine applies bias/activation)
in_base  out  ADDR_W  ic*H*W
w_base  out  ADDR_W  (oc*IC+ic)*K*K
out_base  out  ADDR_W  oc*(H-K+1)*(W-K+1)
oc_idx  out  clog2(OC)  current output channel
ic_idx  out  clog2(IC)  current input channel
cout_done  out  1  one-cycle pulse when an output channel's last pass finishes
layer_done  out  1  one-cycle pulse when all OC*IC passes finish
err  out  1  sticky watchdog flag; constant 0 without the macro

Behaviour:
- Reset: state IDLE; all outputs 0, including addresses, indices, flags and err.
- States:
  - IDLE: start=1 -> ISSUE; oc, ic and all bases cleared to 0.
  - ISSUE: eng_start=1 for exactly this cycle -> WAIT.
  - WAIT: hold until eng_done=1 -> NEXT.
  - NEXT:
    - ic<IC-1: ic++, in_base += H*W, w_base += K*K -> ISSUE.
    - ic==IC-1, oc<OC-1: cout_done=1, oc++, ic=0, in_base=0, w_base += K*K, out_base += OH*OW -> ISSUE.
    - ic==IC-1, oc==OC-1: cout_done=1 -> DONE.
  - DONE: layer_done=1 -> IDLE. Indices and bases hold their last values until the next start.
- Address computation: incremental adders only, no multipliers. Strides H*W, K*K and OH*OW are elaboration-time constants, with OH=H-K+1 and OW=W-K+1. All address and flag outputs are registered and stable from the ISSUE cycle through the end of WAIT.
- eng_accum and eng_last_ic are registered decodes of ic.
- Timing:
  - start to first eng_start: 1 cycle.
  - eng_done to next eng_start: 2 cycles.
  - Minimum pass: 3 cycles.
- Ignored inputs:
  - start while busy is ignored; no restart, no queueing.
  - eng_done outside WAIT (IDLE, ISSUE, NEXT, DONE) is ignored.
  - start in the same cycle as layer_done is ignored, because the FSM is in DONE. Start is honoured from the following IDLE cycle.
- rst in any state wins over all other inputs. The next cycle is IDLE with outputs at reset values; an in-flight engine pass is abandoned.
- IC=1: every pass has eng_accum=0 and eng_last_ic=1.
- OC=1: the single cout_done pulse is followed by layer_done in the next cycle.

Optional Feature:
CONV_SEQ_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT without eng_done: err is set (sticky until rst), the FSM goes to IDLE, and no cout_done or layer_done is issued.
  - A new start clears the pass indices but not err.
- Not defined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Test Plan:
- Default params, start pulsed in cycle 0 -> eng_start in cycle 1 with in_base=0, w_base=0, out_base=0, eng_accum=0, eng_last_ic=0; busy=1 from cycle 1.
- Engine model returns eng_done 5 cycles after each eng_start -> exactly 21 eng_start pulses, 7 cout_done, 1 layer_done. Check specific passes:
  - Pass (oc0, ic2): in_base=1568, w_base=18, eng_last_ic=1.
  - Pass (oc1, ic0): in_base=0, w_base=27, out_base=676, eng_accum=0.
  - Pass (oc6, ic2): w_base=180, out_base=4056.
- Engine model returns eng_done in the first WAIT cycle, start in cycle 0 -> final NEXT in cycle 63, layer_done only in cycle 64, busy=0 in cycle 65.
- start pulsed mid-run, and eng_done pulsed in IDLE and ISSUE -> pass count, indices and addresses unchanged vs. the clean run.
- rst asserted during WAIT at oc=3, ic=1 -> next cycle: busy=0, all outputs 0. A subsequent start issues its first pass with oc_idx=0, ic_idx=0.
- With CONV_SEQ_TIMEOUT_EN, TIMEOUT=16, eng_done never asserted -> err=1 and busy=0 after 16 WAIT cycles, no layer_done. Without the macro, the FSM stays in WAIT and err=0.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks (oc, ic) passes over a single-channel conv engine.
// Optional watchdog enabled by defining CONV_SEQ_TIMEOUT_EN.
module conv_layer_sequencer #(
  parameter int H       = 28,
  parameter int W       = 28,
  parameter int IC      = 3,
  parameter int OC      = 7,
  parameter int K       = 3,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    eng_start,
  input  logic                                    eng_done,
  output logic                                    eng_accum,
  output logic                                    eng_last_ic,
  output logic [ADDR_W-1:0]                       in_base,
  output logic [ADDR_W-1:0]                       w_base,
  output logic [ADDR_W-1:0]                       out_base,
  output logic [((OC > 1) ? $clog2(OC) : 1)-1:0]  oc_idx,
  output logic [((IC > 1) ? $clog2(IC) : 1)-1:0]  ic_idx,
  output logic                                    cout_done,
  output logic                                    layer_done,
  output logic                                    err
);

  localparam int OCW = (OC > 1) ? $clog2(OC) : 1;
  localparam int ICW = (IC > 1) ? $clog2(IC) : 1;
  localparam int OH  = H - K + 1;
  localparam int OW  = W - K + 1;

  localparam logic [ADDR_W-1:0] IN_STRIDE  = ADDR_W'(H * W);
  localparam logic [ADDR_W-1:0] W_STRIDE   = ADDR_W'(K * K);
  localparam logic [ADDR_W-1:0] OUT_STRIDE = ADDR_W'(OH * OW);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [OCW-1:0]    oc_r;
  logic [ICW-1:0]    ic_r;
  logic [ADDR_W-1:0] in_base_r;
  logic [ADDR_W-1:0] w_base_r;
  logic [ADDR_W-1:0] out_base_r;
  logic              busy_r;
  logic              eng_start_r;
  logic              eng_accum_r;
  logic              eng_last_ic_r;
  logic              cout_done_r;
  logic              layer_done_r;
  logic              last_ic_s;
  logic              last_oc_s;
  logic              timeout_hit_s;

  assign last_ic_s = (ic_r == ICW'(IC - 1));
  assign last_oc_s = (oc_r == OCW'(OC - 1));

  // Next-state decode for the pass sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_nxt_s = S_NEXT;
        end else if (timeout_hit_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_NEXT: begin
        if (last_ic_s && last_oc_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, control pulses and incremental address/index bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      oc_r          <= '0;
      ic_r          <= '0;
      in_base_r     <= '0;
      w_base_r      <= '0;
      out_base_r    <= '0;
      busy_r        <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_accum_r   <= 1'b0;
      eng_last_ic_r <= 1'b0;
      cout_done_r   <= 1'b0;
      layer_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
      eng_start_r  <= (state_nxt_s == S_ISSUE);
      cout_done_r  <= (state_r == S_WAIT) && eng_done && last_ic_s;
      layer_done_r <= (state_r == S_NEXT) && last_ic_s && last_oc_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            oc_r          <= '0;
            ic_r          <= '0;
            in_base_r     <= '0;
            w_base_r      <= '0;
            out_base_r    <= '0;
            eng_accum_r   <= 1'b0;
            eng_last_ic_r <= (IC == 1);
          end
        end
        S_NEXT: begin
          if (!last_ic_s) begin
            ic_r          <= ic_r + ICW'(1);
            in_base_r     <= in_base_r + IN_STRIDE;
            w_base_r      <= w_base_r + W_STRIDE;
            eng_accum_r   <= 1'b1;
            eng_last_ic_r <= ((ic_r + ICW'(1)) == ICW'(IC - 1));
          end else if (!last_oc_s) begin
            // Weights are laid out oc-major, so w_base keeps advancing across channels
            oc_r          <= oc_r + OCW'(1);
            ic_r          <= '0;
            in_base_r     <= '0;
            w_base_r      <= w_base_r + W_STRIDE;
            out_base_r    <= out_base_r + OUT_STRIDE;
            eng_accum_r   <= 1'b0;
            eng_last_ic_r <= (IC == 1);
          end
        end
        default: begin
          oc_r <= oc_r;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);

  logic [TOW-1:0] wd_cnt_r;
  logic           err_r;

  assign timeout_hit_s = (wd_cnt_r == TOW'(TIMEOUT - 1));

  // Watchdog: counter restarts on each entry to WAIT, err sticks until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      if (state_r == S_WAIT) begin
        wd_cnt_r <= wd_cnt_r + TOW'(1);
      end else begin
        wd_cnt_r <= '0;
      end
      if ((state_r == S_WAIT) && !eng_done && timeout_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err = err_r;
`else
  // No watchdog in this build: WAIT never times out
  assign timeout_hit_s = (TIMEOUT < 0);
  assign err           = 1'b0;
`endif

  assign busy        = busy_r;
  assign eng_start   = eng_start_r;
  assign eng_accum   = eng_accum_r;
  assign eng_last_ic = eng_last_ic_r;
  assign in_base     = in_base_r;
  assign w_base      = w_base_r;
  assign out_base    = out_base_r;
  assign oc_idx      = oc_r;
  assign ic_idx      = ic_r;
  assign cout_done   = cout_done_r;
  assign layer_done  = layer_done_r;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (default 28x28, IC=3, OC=7, K=3).
// Watchdog checks follow CONV_SEQ_TIMEOUT_EN with TIMEOUT=16.
module tb_conv_layer_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        eng_start;
  logic        eng_done;
  logic        eng_accum;
  logic        eng_last_ic;
  logic [15:0] in_base;
  logic [15:0] w_base;
  logic [15:0] out_base;
  logic [2:0]  oc_idx;
  logic [1:0]  ic_idx;
  logic        cout_done;
  logic        layer_done;
  logic        err;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] r_in  [21];
  logic [15:0] r_w   [21];
  logic [15:0] r_out [21];
  logic        r_acc [21];
  logic        r_last[21];

  conv_layer_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .eng_start(eng_start),
    .eng_done(eng_done), .eng_accum(eng_accum), .eng_last_ic(eng_last_ic),
    .in_base(in_base), .w_base(w_base), .out_base(out_base),
    .oc_idx(oc_idx), .ic_idx(ic_idx), .cout_done(cout_done),
    .layer_done(layer_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {4'd0, busy, eng_start, eng_accum, eng_last_ic, in_base, w_base, out_base,
            oc_idx, ic_idx, cout_done, layer_done, err};
  endfunction

  // Expected pass p from closed-form address equations
  function automatic logic [63:0] exp_pass(input int p);
    int oc, ic;
    oc = p / 3;
    ic = p % 3;
    return {9'd0, 3'(oc), 2'(ic), 16'(ic * 784), 16'((oc * 3 + ic) * 9), 16'(oc * 676),
            1'(ic != 0), 1'(ic == 2)};
  endfunction

  // Runs one layer; engine answers dly cycles after eng_start. inject adds ignored inputs.
  task automatic run_layer(input int dly, input bit inject);
    int n, done_at, npass, ncout, lay_cyc, cout_last;
    bit fin;
    start = 1'b0;
    eng_done = inject;
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1; eng_done = 1'b0;
    n = 0; done_at = -1; npass = 0; ncout = 0; lay_cyc = -1; cout_last = -1; fin = 1'b0;
    while (!fin && n < 1000) begin
      @(negedge clk);
      n++;
      start = 1'b0; eng_done = 1'b0;
      if (n == 1) begin
        check("first_eng_start", eng_start, 1);
        check("first_busy", busy, 1);
      end
      if (eng_start) begin
        if (npass < 21) begin
          r_in[npass] = in_base; r_w[npass] = w_base; r_out[npass] = out_base;
          r_acc[npass] = eng_accum; r_last[npass] = eng_last_ic;
          check("pass", {9'd0, oc_idx, ic_idx, in_base, w_base, out_base, eng_accum, eng_last_ic},
                exp_pass(npass));
        end
        npass++;
        done_at = n + dly;
        eng_done = inject;
      end else if (n == done_at) begin
        eng_done = 1'b1;
      end
      if (cout_done) begin
        ncout++;
        cout_last = n;
      end
      if (layer_done) begin
        lay_cyc = n;
        start = inject;
        fin = 1'b1;
      end else if (inject && busy && (n % 3 == 0)) begin
        start = 1'b1;
      end
    end
    check("layer_done_seen", fin, 1);
    check("pass_count", npass, 21);
    check("cout_count", ncout, 7);
    check("layer_done_cycle", lay_cyc, 21 * (dly + 2) + 1);
    check("last_cout_cycle", cout_last, lay_cyc - 1);
    @(negedge clk);
    start = 1'b0;
    check("post_busy", busy, 0);
    check("post_no_restart", eng_start, 0);
    @(negedge clk);
    check("post_busy2", busy, 0);
    check("post_no_layer_done", layer_done, 0);
  endtask

  // Reset during WAIT of pass (oc3, ic1)
  task automatic reset_mid_run();
    int n, pidx, rst_at, done_at;
    start = 1'b1;
    n = 0; pidx = 0; rst_at = -1; done_at = -1;
    while (n < 300) begin
      @(negedge clk);
      n++;
      start = 1'b0; eng_done = 1'b0; rst = 1'b0;
      if (rst_at >= 0 && n == rst_at + 1) begin
        check("rst_outputs_zero", all_outs(), 64'd0);
        break;
      end
      if (n == rst_at) begin
        check("pre_rst_idx", {oc_idx, ic_idx}, {3'd3, 2'd1});
        rst = 1'b1;
      end else if (eng_start) begin
        if (pidx == 10) rst_at = n + 2;
        pidx++;
        done_at = n + 5;
      end else if (n == done_at) begin
        eng_done = 1'b1;
      end
    end
    check("rst_reached", (rst_at >= 0), 1);
  endtask

  task automatic timeout_test();
    int idle_cyc, nlay, ncout;
    start = 1'b1; eng_done = 1'b0;
    idle_cyc = -1; nlay = 0; ncout = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy && idle_cyc < 0) idle_cyc = n;
      if (layer_done) nlay++;
      if (cout_done) ncout++;
    end
`ifdef CONV_SEQ_TIMEOUT_EN
    check("timeout_idle_cycle", idle_cyc, 18);
    check("timeout_err", err, 1);
`else
    check("wait_forever_busy", busy, 1);
    check("wait_forever_idle", idle_cyc, -1);
    check("no_err", err, 0);
`endif
    check("timeout_no_layer_done", nlay, 0);
    check("timeout_no_cout_done", ncout, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eng_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", all_outs(), 64'd0);
    rst = 1'b0;

    run_layer(5, 1'b0);
    check("p_oc0_ic2_in", r_in[2], 1568);
    check("p_oc0_ic2_w", r_w[2], 18);
    check("p_oc0_ic2_last", r_last[2], 1);
    check("p_oc1_ic0_in", r_in[3], 0);
    check("p_oc1_ic0_w", r_w[3], 27);
    check("p_oc1_ic0_out", r_out[3], 676);
    check("p_oc1_ic0_acc", r_acc[3], 0);
    check("p_oc6_ic2_w", r_w[20], 180);
    check("p_oc6_ic2_out", r_out[20], 4056);

    run_layer(1, 1'b0);
    run_layer(5, 1'b1);
    reset_mid_run();
    run_layer(3, 1'b0);
    timeout_test();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
